spart_rx_fifo: RTL



---
 rtl/spart_rx_if.sv | 28 ++
 rtl/spart_rx_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/spart_rx_if.sv
// Processor-side read port of the SPART receive FIFO.
// Handshake: o_rda is the valid; the read strobe (i_iocs & i_iorw) is the ready, and the head
// entry leaves the FIFO on a clk edge where both are high. A strobe with o_rda low does nothing.
interface spart_rx_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                 i_iocs;
    logic                 i_iorw;
    logic                 o_rda;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_parity_err;
    logic                 o_frame_err;
    logic                 o_overrun;
    logic [CW-1:0]        o_count;

    modport master (
        output i_iocs, i_iorw,
        input  o_rda, o_data, o_parity_err, o_frame_err, o_overrun, o_count
    );

    modport slave (
        input  i_iocs, i_iorw,
        output o_rda, o_data, o_parity_err, o_frame_err, o_overrun, o_count
    );
endinterface

// File: rtl/spart_rx_fifo.sv
// Oversampled serial receiver with start-glitch rejection, parity/framing checks and a small
// receive FIFO with a sticky overrun flag. dbg_state exposes the receiver FSM state.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_b_en,
    input  logic            i_rx,
    spart_rx_if.slave       bus,
    output logic [2:0]      dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 2;
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          PAR_ON    = (PARITY_EN != 0);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    state_t               state, state_nx;
    logic                 rx_s1, rx_s2, rx_prev;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q;
    logic                 tick_done, sample, shift_en, par_en, push_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= i_rx;
            rx_s2 <= rx_s1;
        end
    end

    // START waits half a bit to land mid-bit; every later state waits a full bit.
    assign tick_done = (state == S_START) ? (tick_cnt == HALF_LAST) : (tick_cnt == FULL_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (i_b_en) begin
            case (state)
                S_IDLE:   if (rx_prev && !rx_s2) state_nx = S_START;
                S_START:  if (tick_done) state_nx = rx_s2 ? S_IDLE : S_DATA;
                S_DATA:   if (tick_done && bit_cnt == LAST_BIT)
                              state_nx = PAR_ON ? S_PARITY : S_STOP;
                S_PARITY: if (tick_done) state_nx = S_STOP;
                S_STOP:   if (tick_done) state_nx = S_IDLE;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        sample   = i_b_en && tick_done && (state != S_IDLE);
        shift_en = sample && (state == S_DATA);
        par_en   = sample && (state == S_PARITY);
        push_req = sample && (state == S_STOP);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev  <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr_q   <= 1'b0;
        end else if (i_b_en) begin
            rx_prev <= rx_s2;
            if (state == S_IDLE) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
                perr_q   <= 1'b0;
            end else begin
                tick_cnt <= tick_done ? '0 : tick_cnt + TW'(1);
            end
            // LSB arrives first, so shifting in from the top leaves bit k at position k.
            if (shift_en) begin
                shreg   <= {rx_s2, shreg[DATA_BITS-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end
            if (par_en) perr_q <= (((^shreg) ^ rx_s2) != PAR_ODD);
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [EW-1:0] last_q, head, push_entry;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overrun, pop, full, wr_en;

    assign push_entry = {shreg, perr_q & PAR_ON, ~rx_s2};
    assign pop        = bus.i_iocs && bus.i_iorw && (count != '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    // A full FIFO still accepts a frame when a pop lands on the same edge.
    assign wr_en      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            last_q  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                last_q <= mem[rd_ptr];
            end
            count <= count + CW'(wr_en) - CW'(pop);
            if (pop)                   overrun <= 1'b0;
            else if (push_req && full) overrun <= 1'b1;
        end
    end

    // When empty the outputs keep showing the entry most recently popped.
    assign head             = (count != '0) ? mem[rd_ptr] : last_q;
    assign bus.o_rda        = (count != '0);
    assign bus.o_data       = head[EW-1:2];
    assign bus.o_parity_err = head[1];
    assign bus.o_frame_err  = head[0];
    assign bus.o_overrun    = overrun;
    assign bus.o_count      = count;
endmodule
